step_checker: RTL and testbench
===============================

// Module: step_checker
// PURPOSE
//  Downstream consumer of the stepping counter chain (counter -> +1 -> +1, i.e. +2 per tick).
//  Accepts WIDTH-bit samples over valid/ready and buffers them in a DEPTH-entry FIFO toward the next stage.
//  Checks every accepted sample against the expected arithmetic sequence; tracks lock state and a saturating error count.
// PARAMETERS
//  WIDTH  8   sample width; all sequence arithmetic is mod 2^WIDTH
//  STEP   2   expected increment between consecutive accepted samples
//  DEPTH  4   FIFO entries, power of two, >= 2
//  ERR_W  16  width of err_count
// PORTS
//  clock       in   1       single clock, all state on rising edge
//  reset       in   1       synchronous, active-high
//  in_valid    in   1       upstream sample valid
//  in_data     in   WIDTH   upstream sample
//  in_ready    out  1       block can accept; = (fifo count < DEPTH)
//  out_valid   out  1       FIFO non-empty
//  out_data    out  WIDTH   FIFO head
//  out_ready   in   1       downstream accepts head
//  seq_locked  out  1       high only in state LOCKED
//  mismatch    out  1       one-cycle pulse, cycle after a failed compare
//  err_count   out  ERR_W   failed compares, saturates at all-ones
// BEHAVIOUR
//  Reset: FIFO flushed (count 0), out_valid 0, out_data 0, in_ready 1, state IDLE, expected 0,
//   match_run 0, seq_locked 0, mismatch 0, err_count 0. Reset mid-stream discards all buffered data.
//  Accept = in_valid & in_ready; pop = out_valid & out_ready. Push and pop in the same cycle both take effect.
//  in_ready depends only on registered count (no full-bypass): when full, in_ready=0 even if out_ready=1.
//  Latency: sample accepted at edge N is out_data/out_valid after edge N when FIFO was empty (1 cycle), FIFO order strict.
//  Pointers wrap mod DEPTH; count in 0..DEPTH; never push when full, never pop when empty.
//  Checker acts only on accept cycles; idle cycles change nothing. expected <= in_data + STEP (mod 2^WIDTH) on every accept.
//  FSM (checker):
//   IDLE   : accept -> LOCKED, no compare (first sample defines sequence).
//   LOCKED : accept & in_data==expected -> LOCKED; else -> SLIP, err_count++ (sat), mismatch=1 next cycle, match_run=0.
//   SLIP   : accept & match -> match_run++; match_run reaches 2 -> LOCKED, match_run=0.
//            accept & miss -> stay SLIP, err_count++ (sat), mismatch pulse, match_run=0.
//  Wrap-around: 0xFF then 0x01 with STEP=2 is a match (0xFF+2 = 0x01 mod 256).
//  err_count at all-ones stays all-ones; mismatch still pulses.
//  Checker is independent of downstream stall: compare happens at input acceptance, not at pop.
//  mismatch is a registered pulse: exactly one cycle per failed compare; back-to-back misses give back-to-back pulses.
// STRUCTURE
//  Package step_checker_pkg: typedef enum {IDLE, LOCKED, SLIP} chk_state_t; RELOCK_MATCHES = 2.
//  Sub-module sync_fifo (WIDTH, DEPTH): storage, rd/wr pointers, count, full/empty; reusable.
//  Top: FSM, expected register, match_run (2 bits), err_count saturating counter, glue.
// TESTING
//  1 reset, then in 0x10,0x12,0x14 with out_ready=1 -> out_data 0x10,0x12,0x14 in order, seq_locked=1 from 2nd cycle, err_count=0.
//  2 in 0xFE,0x00,0x02 (wrap) -> no mismatch, seq_locked stays 1.
//  3 locked at 0x20, send 0x25 -> mismatch one cycle, seq_locked=0, err_count=1; then 0x27,0x29 -> relock after 0x29.
//  4 out_ready=0, in_valid=1 constant for 6 cycles -> exactly 4 accepted, in_ready=0 after 4th; release -> 4 pops in order.
//  5 full FIFO, push+pop same cycle not possible; count 2 with push+pop -> count stays 2, order preserved.
//  6 ERR_W=2, 5 consecutive misses -> err_count 1,2,3,3,3; mismatch pulses 5 times; reset mid-stream -> out_valid 0, state IDLE.

Source files
------------

// File: rtl/step_checker_pkg.sv
// Shared types and constants for the step_checker sequence monitor.
package step_checker_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    SLIP   = 2'd2
  } chk_state_t;

  // Consecutive good samples needed in SLIP before declaring lock again.
  localparam int RELOCK_MATCHES = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read; no full bypass.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [CW-1:0]               count;
  logic                        wr, rd;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign wr    = push & ~full;
  assign rd    = pop & ~empty;
  assign head  = mem[rd_ptr];

  // Storage is cleared on reset so the head reads 0 while empty after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      case ({wr, rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/step_checker.sv
// Buffers upstream samples and checks them against an arithmetic sequence
// (previous accepted sample + STEP), tracking lock and a saturating error count.
module step_checker
  import step_checker_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 2,
  parameter int DEPTH = 4,
  parameter int ERR_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             seq_locked,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count
);
  chk_state_t       state;
  logic [WIDTH-1:0] expected;
  logic [1:0]       match_run;
  logic             full, empty, accept, pop, hit;

  assign in_ready   = ~full;
  assign out_valid  = ~empty;
  assign accept     = in_valid & in_ready;
  assign pop        = out_valid & out_ready;
  assign hit        = (in_data == expected);
  assign seq_locked = (state == LOCKED);

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (accept),
    .push_data (in_data),
    .pop       (pop),
    .head      (out_data),
    .full      (full),
    .empty     (empty)
  );

  // The checker only advances on accepted samples; stalls downstream are invisible to it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      expected  <= '0;
      match_run <= '0;
      mismatch  <= 1'b0;
      err_count <= '0;
    end else begin
      mismatch <= 1'b0;
      if (accept) begin
        expected <= in_data + WIDTH'(STEP);
        case (state)
          IDLE: state <= LOCKED;
          LOCKED, SLIP: begin
            if (!hit) begin
              state     <= SLIP;
              match_run <= '0;
              mismatch  <= 1'b1;
              if (err_count != '1) err_count <= err_count + ERR_W'(1);
            end else if (state == SLIP) begin
              if (match_run == 2'(RELOCK_MATCHES - 1)) begin
                state     <= LOCKED;
                match_run <= '0;
              end else begin
                match_run <= match_run + 2'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_step_checker.sv
// Directed bench for step_checker with a queue-based reference model checked every cycle.
module tb_step_checker;
  localparam int WIDTH = 8;
  localparam int STEP  = 2;
  localparam int DEPTH = 4;
  localparam int ERR_W = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             seq_locked;
  logic             mismatch;
  logic [ERR_W-1:0] err_count;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  step_checker #(.WIDTH(WIDTH), .STEP(STEP), .DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .seq_locked (seq_locked),
    .mismatch   (mismatch),
    .err_count  (err_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue; checker as "has a sequence started",
  // "is locked", and a count of consecutive good samples while unlocked.
  logic [WIDTH-1:0] m_q[$];
  bit               m_started, m_locked, m_mis;
  int               m_good, m_err;
  logic [WIDTH-1:0] m_exp;

  always @(posedge clock) begin
    if (reset) begin
      m_q.delete();
      m_started = 0; m_locked = 0; m_mis = 0;
      m_good = 0; m_err = 0; m_exp = '0;
    end else begin
      bit acc, pp;
      acc   = in_valid && (m_q.size() < DEPTH);
      pp    = out_ready && (m_q.size() > 0);
      m_mis = 0;
      if (pp) void'(m_q.pop_front());
      if (acc) begin
        m_q.push_back(in_data);
        if (!m_started) begin
          m_started = 1; m_locked = 1;
        end else if (in_data == m_exp) begin
          if (!m_locked) begin
            m_good++;
            if (m_good == 2) begin m_locked = 1; m_good = 0; end
          end
        end else begin
          m_locked = 0; m_good = 0; m_mis = 1;
          m_err = (m_err + 1 > 3) ? 3 : m_err + 1;
        end
        m_exp = WIDTH'(in_data + STEP);
      end
    end
  end

  always @(negedge clock) begin
    if (armed) begin
      check("in_ready",   32'(in_ready),   32'(m_q.size() < DEPTH));
      check("out_valid",  32'(out_valid),  32'(m_q.size() > 0));
      if (m_q.size() > 0) check("out_data", 32'(out_data), 32'(m_q[0]));
      check("seq_locked", 32'(seq_locked), 32'(m_locked));
      check("mismatch",   32'(mismatch),   32'(m_mis));
      check("err_count",  32'(err_count),  32'(m_err));
    end
  end

  task automatic send(input logic v, input logic [WIDTH-1:0] d, input logic r);
    in_valid = v; in_data = d; out_ready = r;
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    int acc_cnt, pulses;
    logic [WIDTH-1:0] d;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    armed = 1'b1;
    check("rst_out_valid",  32'(out_valid),  0);
    check("rst_out_data",   32'(out_data),   0);
    check("rst_in_ready",   32'(in_ready),   1);
    check("rst_seq_locked", 32'(seq_locked), 0);
    check("rst_err_count",  32'(err_count),  0);
    reset = 1'b0;

    // 1: basic in-order flow with lock after first sample
    send(1, 8'h10, 1);
    check("t1_head0",   32'(out_data),   32'h10);
    check("t1_locked",  32'(seq_locked), 1);
    send(1, 8'h12, 1);
    check("t1_head1",   32'(out_data),   32'h12);
    send(1, 8'h14, 1);
    check("t1_head2",   32'(out_data),   32'h14);
    check("t1_err",     32'(err_count),  0);
    send(0, 8'h00, 1);

    // 2: wrap-around is a match
    do_reset();
    send(1, 8'hFE, 1);
    send(1, 8'h00, 1);
    check("t2_mis0", 32'(mismatch), 0);
    send(1, 8'h02, 1);
    check("t2_mis1", 32'(mismatch), 0);
    check("t2_lock", 32'(seq_locked), 1);
    send(0, 8'h00, 1);

    // 3: slip and relock after two good samples
    do_reset();
    send(1, 8'h20, 1);
    send(1, 8'h25, 1);
    check("t3_mis",    32'(mismatch),   1);
    check("t3_unlock", 32'(seq_locked), 0);
    check("t3_err",    32'(err_count),  1);
    send(1, 8'h27, 1);
    check("t3_pulse1", 32'(mismatch),   0);
    check("t3_slip",   32'(seq_locked), 0);
    send(1, 8'h29, 1);
    check("t3_relock", 32'(seq_locked), 1);
    send(0, 8'h00, 1);

    // 4: backpressure, exactly DEPTH accepted, then in-order drain
    do_reset();
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (in_ready) acc_cnt++;
      send(1, 8'h40 + 8'(2 * i), 0);
    end
    check("t4_accepted", 32'(acc_cnt),  4);
    check("t4_full",     32'(in_ready), 0);
    for (int i = 0; i < 4; i++) begin
      check("t4_drain", 32'(out_data), 32'(8'h40 + 8'(2 * i)));
      send(0, 8'h00, 1);
    end
    check("t4_empty", 32'(out_valid), 0);

    // 5: simultaneous push and pop at count 2
    do_reset();
    send(1, 8'h50, 0);
    send(1, 8'h52, 0);
    send(1, 8'h54, 1);
    check("t5_head",  32'(out_data), 32'h52);
    check("t5_ready", 32'(in_ready), 1);
    send(0, 8'h00, 1);
    check("t5_head2", 32'(out_data), 32'h54);
    send(0, 8'h00, 1);
    check("t5_empty", 32'(out_valid), 0);

    // 6: saturating error count, back-to-back pulses, reset mid-stream
    do_reset();
    send(1, 8'h00, 1);
    pulses = 0;
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i * 16);
      send(1, d, 1);
      if (mismatch) pulses++;
      check("t6_err", 32'(err_count), (i < 3) ? i : 3);
    end
    check("t6_pulses", 32'(pulses), 5);
    send(1, 8'h60, 0);
    send(1, 8'h62, 0);
    do_reset();
    check("t6_rst_valid",  32'(out_valid),  0);
    check("t6_rst_locked", 32'(seq_locked), 0);
    check("t6_rst_err",    32'(err_count),  0);
    send(1, 8'h77, 1);
    check("t6_idle_first", 32'(mismatch),   0);
    check("t6_idle_lock",  32'(seq_locked), 1);
    send(0, 8'h00, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: simulation did not finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
